// File: rtl/sprite_line_reader_if.sv
// Sprite memory read bus: the reader drives row/column addresses, memory answers combinationally.
interface sprite_line_reader_if;
  logic [7:0]  ram_addr_x;
  logic [7:0]  ram_addr_y;
  logic [15:0] ram_data;

  modport master (output ram_addr_x, output ram_addr_y, input ram_data);
  modport slave  (input ram_addr_x, input ram_addr_y, output ram_data);
endinterface

// File: rtl/sprite_line_reader.sv
// Fetches one sprite row per horizontal blank into a line buffer and replays it with colour-key
// transparency on the next active line. Optional horizontal mirroring: define SPRITE_MIRROR_EN.
module sprite_line_reader #(
  parameter int          SPR_W     = 64,
  parameter int          SPR_H     = 64,
  parameter int          H_ACTIVE  = 640,
  parameter int          H_TOTAL   = 800,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_TOTAL   = 525,
  parameter logic [15:0] TRANS_KEY = 16'hF0F0
) (
  input  logic                        clk_25,
  input  logic                        rst,
  input  logic [9:0]                  h_cnt,
  input  logic [9:0]                  v_cnt,
  input  logic [9:0]                  pos_x,
  input  logic [9:0]                  pos_y,
  input  logic                        flip_x,
  sprite_line_reader_if.master        mem,
  output logic [11:0]                 pixel,
  output logic                        pixel_valid,
  output logic                        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int             IW   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam logic [IW-1:0]  LAST = IW'(SPR_W - 1);
  localparam logic [10:0]    HA   = 11'(H_ACTIVE);
  localparam logic [10:0]    VA   = 11'(V_ACTIVE);
  localparam logic [10:0]    VL   = 11'(V_TOTAL - 1);
  localparam logic [10:0]    SW   = 11'(SPR_W);
  localparam logic [10:0]    SH   = 11'(SPR_H);

  function automatic logic [11:0] rgb444(input logic [15:0] d);
    return {d[15:12], d[11:8], d[7:4]};
  endfunction

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [7:0]    row;
  logic [9:0]    lx, ly;
  logic          line_ok;
  logic [7:0]    addr_col;
  logic [15:0]   line_buf [SPR_W];

  logic [10:0] h11, v11, nv, lx11, ly11;
  logic        start_ok;

  // All position arithmetic is 11-bit so sprites hanging off the screen clip instead of wrapping.
  assign h11      = {1'b0, h_cnt};
  assign v11      = {1'b0, v_cnt};
  assign lx11     = {1'b0, lx};
  assign ly11     = {1'b0, ly};
  assign nv       = (v11 == VL) ? 11'd0 : v11 + 11'd1;
  assign start_ok = (nv < VA) && (ly11 <= nv) && (nv < ly11 + SH);

`ifdef SPRITE_MIRROR_EN
  logic lf;
  assign addr_col = lf ? (8'(SPR_W - 1) - 8'(idx)) : 8'(idx);
`else
  logic unused_flip;
  assign unused_flip = flip_x;
  assign addr_col    = 8'(idx);
`endif

  logic [10:0] unused_htotal;
  assign unused_htotal = 11'(H_TOTAL);

  assign busy           = (state == FETCH);
  assign mem.ram_addr_x = (state == FETCH) ? addr_col : 8'd0;
  assign mem.ram_addr_y = (state == FETCH) ? row : 8'd0;

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      row     <= 8'd0;
      line_ok <= 1'b0;
      lx      <= 10'd0;
      ly      <= 10'd0;
`ifdef SPRITE_MIRROR_EN
      lf      <= 1'b0;
`endif
    end else begin
      // Position is frozen for the whole frame, sampled at the start of vertical blank.
      if (h11 == 11'd0 && v11 == VA) begin
        lx <= pos_x;
        ly <= pos_y;
`ifdef SPRITE_MIRROR_EN
        lf <= flip_x;
`endif
      end
      case (state)
        IDLE: begin
          if (h11 == HA) begin
            if (start_ok) begin
              state <= FETCH;
              idx   <= '0;
              row   <= 8'(nv - ly11);
            end else begin
              line_ok <= 1'b0;
            end
          end
        end
        FETCH: begin
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            state   <= DONE;
            line_ok <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_25) begin
    if (state == FETCH) line_buf[idx] <= mem.ram_data;
  end

  // Stage p0: buffer lookup for the incoming (h, v); registered to the outputs below.
  logic [IW-1:0] off_p0;
  logic          in_x_p0;
  logic [15:0]   rd_p0;

  assign off_p0  = IW'(h11 - lx11);
  assign in_x_p0 = (h11 < HA) && (v11 < VA) && (h11 >= lx11) && (h11 < lx11 + SW);
  assign rd_p0   = line_buf[off_p0];

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      pixel       <= 12'd0;
      pixel_valid <= 1'b0;
    end else if (line_ok && in_x_p0 && (rd_p0 != TRANS_KEY)) begin
      pixel       <= rgb444(rd_p0);
      pixel_valid <= 1'b1;
    end else begin
      pixel       <= 12'd0;
      pixel_valid <= 1'b0;
    end
  end

endmodule
